// File: rtl/d_term.sv
`default_nettype none
// ============================================================================
// Module   : d_term
// Brief    : Derivative term of a PID loop. Each new error sample is
//            differenced against the sample HIST_DEPTH valid samples back.
//            The difference is saturated to 8 bits and then scaled by D_COEFF.
// Revision : 1.0 - initial release
// ============================================================================
module d_term #(
    parameter int                HIST_DEPTH = 2,
    parameter logic signed [4:0] D_COEFF    = 5'sd7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               moving,
    input  logic               err_vld,
    input  logic signed [9:0]  err_sat,
    output logic signed [12:0] D_term,
    output logic               D_vld
);

    localparam int               CNT_W       = $clog2(HIST_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FILL_LAST = CNT_W'(HIST_DEPTH - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_fill_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      w_load;
    logic signed [9:0]         r_hist [HIST_DEPTH];
    logic signed [12:0]        r_term;
    logic                      r_vld;

    logic signed [9:0]         w_ref;
    logic signed [10:0]        w_diff;
    logic signed [7:0]         w_sat;
    logic signed [12:0]        w_sat_ext;
    logic signed [12:0]        w_coef_ext;
    logic signed [12:0]        w_prod;

    // The reference is read before the shift, so the product uses the pre-shift history.
    assign w_ref      = r_hist[HIST_DEPTH-1];
    assign w_diff     = {err_sat[9], err_sat} - {w_ref[9], w_ref};
    assign w_sat      = (w_diff > 11'sd127)  ? 8'sd127 :
                        (w_diff < -11'sd128) ? -8'sd128 : w_diff[7:0];
    assign w_sat_ext  = {{5{w_sat[7]}}, w_sat};
    assign w_coef_ext = {{8{D_COEFF[4]}}, D_COEFF};
    assign w_prod     = w_sat_ext * w_coef_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_cnt_nxt;
        end
    end

    // Dropping moving outranks a coincident sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_fill_cnt;
        w_load      = 1'b0;
        if (!moving) begin
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
        end else if (err_vld) begin
            case (r_state)
                FILL: begin
                    w_cnt_nxt = r_fill_cnt + CNT_W'(1);
                    if (r_fill_cnt == C_FILL_LAST) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    w_load = 1'b1;
                end
                default: begin
                    w_state_nxt = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (!moving) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (err_vld) begin
            r_hist[0] <= err_sat;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_term <= '0;
            r_vld  <= 1'b0;
        end else if (!moving) begin
            r_term <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= w_load;
            if (w_load) begin
                r_term <= w_prod;
            end
        end
    end

    assign D_term = r_term;
    assign D_vld  = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_d_term.sv
`default_nettype none
// Directed self-checking bench for d_term at default parameters (HIST_DEPTH=2, D_COEFF=7).
module tb_d_term;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               moving;
    logic               err_vld;
    logic signed [9:0]  err_sat;
    logic signed [12:0] D_term;
    logic               D_vld;

    int checks = 0;
    int errors = 0;

    d_term dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .moving  (moving),
        .err_vld (err_vld),
        .err_sat (err_sat),
        .D_term  (D_term),
        .D_vld   (D_vld)
    );

    always #5 clk = ~clk;

    task automatic drive_sample(input logic [9:0] v);
        err_sat = v;
        err_vld = 1'b1;
        @(posedge clk);
        #1;
        err_vld = 1'b0;
    endtask

    task automatic idle_cycle();
        err_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        moving  = 1'b0;
        err_vld = 1'b0;
        @(posedge clk);
        #1;
        moving = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        moving  = 1'b1;
        err_vld = 1'b1;
        err_sat = 10'h155;
        #3;
        checks++;
        if (D_term !== 13'h0000) begin
            errors++;
            $display("FAIL reset_dterm: got %h expected 0000", D_term);
        end
        checks++;
        if (D_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_dvld: got %b expected 0", D_vld);
        end
        err_vld = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_step();
        logic [9:0]  smp  [5] = '{10'd0, 10'd0, 10'd32, 10'd32, 10'd32};
        logic [12:0] expd [5] = '{13'd0, 13'd0, 13'd224, 13'd224, 13'd0};
        logic        expv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        clear_hist();
        for (int i = 0; i < 5; i++) begin
            drive_sample(smp[i]);
            checks++;
            if (D_vld !== expv[i] || D_term !== expd[i]) begin
                errors++;
                $display("FAIL fill_step[%0d]: got D_term=%0d D_vld=%b expected D_term=%0d D_vld=%b",
                         i, D_term, D_vld, $signed(expd[i]), expv[i]);
            end
        end
        idle_cycle();
        checks++;
        if (D_vld !== 1'b0) begin
            errors++;
            $display("FAIL fill_step_vld_drop: got %b expected 0", D_vld);
        end
    endtask

    task automatic test_pos_sat();
        clear_hist();
        drive_sample(10'h200);
        drive_sample(10'h200);
        drive_sample(10'h1FF);
        checks++;
        if (D_term !== 13'h0379 || D_vld !== 1'b1) begin
            errors++;
            $display("FAIL pos_sat: got D_term=%h D_vld=%b expected 0379 1", D_term, D_vld);
        end
    endtask

    task automatic test_neg_sat();
        clear_hist();
        drive_sample(10'h1FF);
        drive_sample(10'h1FF);
        drive_sample(10'h200);
        checks++;
        if (D_term !== 13'h1C80 || D_vld !== 1'b1) begin
            errors++;
            $display("FAIL neg_sat: got D_term=%h D_vld=%b expected 1c80 1", D_term, D_vld);
        end
    endtask

    task automatic test_gaps();
        clear_hist();
        drive_sample(10'd10);
        drive_sample(10'd10);
        drive_sample(10'd20);
        checks++;
        if (D_term !== 13'd70 || D_vld !== 1'b1) begin
            errors++;
            $display("FAIL gaps_first: got D_term=%0d D_vld=%b expected 70 1", D_term, D_vld);
        end
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            checks++;
            if (D_term !== 13'd70 || D_vld !== 1'b0) begin
                errors++;
                $display("FAIL gaps_hold[%0d]: got D_term=%0d D_vld=%b expected 70 0", i, D_term, D_vld);
            end
        end
        // Reference after the gap must still be 10 (two samples back).
        drive_sample(10'd50);
        checks++;
        if (D_term !== 13'd280 || D_vld !== 1'b1) begin
            errors++;
            $display("FAIL gaps_next: got D_term=%0d D_vld=%b expected 280 1", D_term, D_vld);
        end
    endtask

    task automatic test_moving_drop();
        clear_hist();
        drive_sample(10'd0);
        drive_sample(10'd0);
        drive_sample(10'd32);
        moving  = 1'b0;
        err_vld = 1'b1;
        err_sat = 10'd100;
        @(posedge clk);
        #1;
        moving  = 1'b1;
        err_vld = 1'b0;
        checks++;
        if (D_term !== 13'd0 || D_vld !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear: got D_term=%0d D_vld=%b expected 0 0", D_term, D_vld);
        end
        drive_sample(10'd5);
        checks++;
        if (D_vld !== 1'b0) begin
            errors++;
            $display("FAIL drop_refill1: got D_vld=%b expected 0", D_vld);
        end
        drive_sample(10'd5);
        checks++;
        if (D_vld !== 1'b0) begin
            errors++;
            $display("FAIL drop_refill2: got D_vld=%b expected 0", D_vld);
        end
        drive_sample(10'd9);
        checks++;
        if (D_term !== 13'd28 || D_vld !== 1'b1) begin
            errors++;
            $display("FAIL drop_refill3: got D_term=%0d D_vld=%b expected 28 1", D_term, D_vld);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_hist();
        drive_sample(10'd0);
        drive_sample(10'd0);
        drive_sample(10'd32);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (D_term !== 13'd0 || D_vld !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got D_term=%0d D_vld=%b expected 0 0", D_term, D_vld);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive_sample(10'd1);
        checks++;
        if (D_vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_refill1: got D_vld=%b expected 0", D_vld);
        end
        drive_sample(10'd1);
        checks++;
        if (D_vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_refill2: got D_vld=%b expected 0", D_vld);
        end
        drive_sample(10'd4);
        checks++;
        if (D_term !== 13'd21 || D_vld !== 1'b1) begin
            errors++;
            $display("FAIL rst_refill3: got D_term=%0d D_vld=%b expected 21 1", D_term, D_vld);
        end
    endtask

    initial begin
        test_reset();
        test_fill_step();
        test_pos_sat();
        test_neg_sat();
        test_gaps();
        test_moving_drop();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
